// File: rtl/fifo_sched_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sched_pkg
// Shared definitions for the FIFO port scheduler: priority-state type, the
// depth and counter width of the attached FIFO, the default data width and a
// saturating increment helper used by the issue counters.
// -----------------------------------------------------------------------------
package fifo_sched_pkg;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned DEF_DW     = 8;

  // Which operation wins when a read and a write are both eligible.
  typedef enum logic [0:0] {
    PRI_WR = 1'b0,
    PRI_RD = 1'b1
  } sched_pri_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] i_val);
    return (&i_val) ? i_val : i_val + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Starting at index i_ptr and
// searching upward with wrap from N-1 to 0, the first set request wins.
// The pointer register is owned by the instantiating block.
//
// Ports:
//   i_req      N     request vector
//   i_ptr      IDXW  index searched first
//   o_gnt      N     one-hot grant, zero when no request is set
//   o_gnt_idx  IDXW  index of the granted request (0 when none)
//   o_any      1     at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [IDXW-1:0] o_gnt_idx,
  output logic            o_any
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IDXW:0] w_pos;
  logic          w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_pos     = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, i_ptr} + (IDXW+1)'(k);
      if (w_pos >= (IDXW+1)'(N)) begin
        w_pos = w_pos - (IDXW+1)'(N);
      end
      if (!w_found && i_req[w_pos[IDXW-1:0]]) begin
        w_found                   = 1'b1;
        o_gnt[w_pos[IDXW-1:0]]    = 1'b1;
        o_gnt_idx                 = w_pos[IDXW-1:0];
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/fifo_port_sched.sv
// -----------------------------------------------------------------------------
// fifo_port_sched
// Access scheduler in front of a 16-deep synchronous FIFO. NUM_WR producers
// share the single write port through round-robin arbitration, and their
// writes are interleaved with one consumer's reads so that at most one FIFO
// operation is issued per cycle (the FIFO drops a read that coincides with an
// accepted write). Issue decisions are combinational from the current
// requests and FIFO flags.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   i_wr_req         per-producer write request (held until acked)
//   i_wr_data        producer data, slice i = [i*DW +: DW]
//   o_wr_ack         one-hot/zero; data of producer i taken at this edge
//   i_rd_req         consumer read request
//   o_rd_ack         read issued to the FIFO this cycle
//   o_rd_valid       registered; high the cycle after o_rd_ack
//   o_rd_data        FIFO dout passthrough, meaningful with o_rd_valid
//   o_fifo_wr/rd     FIFO write/read strobes (never both high)
//   o_fifo_din       FIFO write data
//   i_fifo_dout      FIFO read data
//   i_fifo_full/empty current-cycle FIFO flags
//   o_wr_cnt/rd_cnt  saturating counts of issued writes/reads
// -----------------------------------------------------------------------------
module fifo_port_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NUM_WR = 4,
  parameter int unsigned DW     = DEF_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    i_wr_req,
  input  logic [NUM_WR*DW-1:0] i_wr_data,
  output logic [NUM_WR-1:0]    o_wr_ack,
  input  logic                 i_rd_req,
  output logic                 o_rd_ack,
  output logic                 o_rd_valid,
  output logic [DW-1:0]        o_rd_data,
  output logic                 o_fifo_wr,
  output logic                 o_fifo_rd,
  output logic [DW-1:0]        o_fifo_din,
  input  logic [DW-1:0]        i_fifo_dout,
  input  logic                 i_fifo_full,
  input  logic                 i_fifo_empty,
  output logic [CNT_W-1:0]     o_wr_cnt,
  output logic [CNT_W-1:0]     o_rd_cnt
);

  localparam int unsigned IDXW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  sched_pri_e          r_pri;
  sched_pri_e          w_pri_next;
  logic [IDXW-1:0]     r_ptr;
  logic                r_rd_valid;
  logic [CNT_W-1:0]    r_wr_cnt;
  logic [CNT_W-1:0]    r_rd_cnt;

  logic [NUM_WR-1:0]   w_gnt;
  logic [IDXW-1:0]     w_gnt_idx;
  logic                w_any_req;
  logic                w_wr_elig;
  logic                w_rd_elig;
  logic                w_do_wr;
  logic                w_do_rd;
  logic [IDXW-1:0]     w_ptr_next;

  rr_arbiter #(
    .N    (NUM_WR),
    .IDXW (IDXW)
  ) u_rr_arbiter (
    .i_req     (i_wr_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any_req)
  );

  assign w_wr_elig = w_any_req && !i_fifo_full;
  assign w_rd_elig = i_rd_req && !i_fifo_empty;

  // Priority FSM: next state and the single issued operation. Reset
  // suppresses issue combinationally so nothing reaches the FIFO in that cycle.
  always_comb begin
    w_pri_next = r_pri;
    w_do_wr    = 1'b0;
    w_do_rd    = 1'b0;
    if (!rst) begin
      unique case (r_pri)
        PRI_WR: begin
          if (w_wr_elig) begin
            w_do_wr = 1'b1;
          end else if (w_rd_elig) begin
            w_do_rd = 1'b1;
          end
        end
        PRI_RD: begin
          if (w_rd_elig) begin
            w_do_rd = 1'b1;
          end else if (w_wr_elig) begin
            w_do_wr = 1'b1;
          end
        end
        default: begin
          w_do_wr = 1'b0;
          w_do_rd = 1'b0;
        end
      endcase
      if (w_do_wr) begin
        w_pri_next = PRI_RD;
      end else if (w_do_rd) begin
        w_pri_next = PRI_WR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pri <= PRI_WR;
    end else begin
      r_pri <= w_pri_next;
    end
  end

  // Pointer moves just past the granted producer, wrapping at NUM_WR-1.
  assign w_ptr_next = (w_gnt_idx == IDXW'(NUM_WR - 1)) ? '0 : w_gnt_idx + IDXW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_rd_valid <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
    end else begin
      r_rd_valid <= w_do_rd;
      if (w_do_wr) begin
        r_ptr    <= w_ptr_next;
        r_wr_cnt <= sat_inc(r_wr_cnt);
      end
      if (w_do_rd) begin
        r_rd_cnt <= sat_inc(r_rd_cnt);
      end
    end
  end

  // Write data mux driven by the one-hot grant.
  always_comb begin
    o_fifo_din = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (w_gnt[i]) begin
        o_fifo_din = i_wr_data[i*DW +: DW];
      end
    end
  end

  assign o_wr_ack   = w_do_wr ? w_gnt : '0;
  assign o_fifo_wr  = w_do_wr;
  assign o_rd_ack   = w_do_rd;
  assign o_fifo_rd  = w_do_rd;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = i_fifo_dout;
  assign o_wr_cnt   = r_wr_cnt;
  assign o_rd_cnt   = r_rd_cnt;

endmodule

// File: tb/tb_fifo_port_sched.sv
// Self-checking bench for fifo_port_sched with a behavioural 16-deep FIFO
// attached to the scheduler's FIFO pins and a queue-based reference model.
module tb_fifo_port_sched;
  import fifo_sched_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    wr_req;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    wr_ack;
  logic            rd_req;
  logic            rd_ack;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic            fifo_wr;
  logic            fifo_rd;
  logic [DW-1:0]   fifo_din;
  logic [DW-1:0]   fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [15:0]     wr_cnt;
  logic [15:0]     rd_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_port_sched #(
    .NUM_WR (N),
    .DW     (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_wr_req     (wr_req),
    .i_wr_data    (wr_data),
    .o_wr_ack     (wr_ack),
    .i_rd_req     (rd_req),
    .o_rd_ack     (rd_ack),
    .o_rd_valid   (rd_valid),
    .o_rd_data    (rd_data),
    .o_fifo_wr    (fifo_wr),
    .o_fifo_rd    (fifo_rd),
    .o_fifo_din   (fifo_din),
    .i_fifo_dout  (fifo_dout),
    .i_fifo_full  (fifo_full),
    .i_fifo_empty (fifo_empty),
    .o_wr_cnt     (wr_cnt),
    .o_rd_cnt     (rd_cnt)
  );

  // Environment FIFO: registered dout, cleared only by the bench's fifo_clr.
  logic          fifo_clr = 1'b0;
  logic [DW-1:0] fq[$];
  int            fcount = 0;

  assign fifo_full  = (fcount == FIFO_DEPTH);
  assign fifo_empty = (fcount == 0);

  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
      fcount <= 0;
    end else if (fifo_wr && fcount < FIFO_DEPTH) begin
      fq.push_back(fifo_din);
      fcount <= fcount + 1;
    end else if (fifo_rd && fcount > 0) begin
      fifo_dout <= fq.pop_front();
      fcount    <= fcount - 1;
    end
  end

  // Reference model state.
  int            m_ptr = 0;
  bit            m_fav_rd = 1'b0;
  bit            m_rdv = 1'b0;
  int            m_wcnt = 0;
  int            m_rcnt = 0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] mq[$];

  bit            p_wr;
  bit            p_rd;
  int            p_g;
  logic [N-1:0]  e_ack;
  logic [DW-1:0] e_din;

  // Expected issue for the inputs currently applied.
  task automatic predict();
    bit we;
    bit re;
    int idx;
    p_g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (p_g < 0 && wr_req[idx]) p_g = idx;
    end
    we    = (p_g >= 0) && (mq.size() < FIFO_DEPTH);
    re    = rd_req && (mq.size() > 0);
    p_wr  = !rst && we && (!re || !m_fav_rd);
    p_rd  = !rst && re && !p_wr;
    e_ack = p_wr ? (N'(1) << p_g) : '0;
    e_din = p_wr ? wr_data[p_g*DW +: DW] : '0;
  endtask

  // Apply the clock edge to the model, then step to just after the edge.
  task automatic advance();
    if (rst) begin
      m_ptr = 0; m_fav_rd = 1'b0; m_rdv = 1'b0; m_wcnt = 0; m_rcnt = 0;
      if (fifo_clr) mq.delete();
    end else begin
      if (p_wr) begin
        mq.push_back(wr_data[p_g*DW +: DW]);
        m_ptr    = (p_g + 1) % N;
        m_fav_rd = 1'b1;
        if (m_wcnt < 65535) m_wcnt++;
      end
      if (p_rd) begin
        m_rdata  = mq.pop_front();
        m_fav_rd = 1'b0;
        if (m_rcnt < 65535) m_rcnt++;
      end
      m_rdv = p_rd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_clr = 1'b1; wr_req = '0; rd_req = 1'b0; wr_data = '0;
    repeat (2) begin
      @(negedge clk); predict(); advance();
    end
    rst = 1'b0; fifo_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_clr = 1'b1; wr_req = '1; rd_req = 1'b1; wr_data = 32'h8c4a_17e3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); predict();
      n_cmp++; if (wr_ack !== '0) begin n_fail++; $display("FAIL reset_wr_ack got %h want 0", wr_ack); end
      n_cmp++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ack got %b want 0", rd_ack); end
      n_cmp++; if (fifo_wr !== 1'b0 || fifo_rd !== 1'b0) begin
        n_fail++; $display("FAIL reset_strobes got wr=%b rd=%b want 0 0", fifo_wr, fifo_rd);
      end
      advance();
    end
    rst = 1'b0; fifo_clr = 1'b0;
    @(negedge clk); predict();
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_cmp++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnts got %0d/%0d want 0/0", wr_cnt, rd_cnt);
    end
    n_cmp++; if (wr_ack !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b want 0001", wr_ack); end
    advance();
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_rd [5];
    exp_rd = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    wr_data = {8'h13, 8'h12, 8'h11, 8'h10}; wr_req = '1; rd_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); predict();
      n_cmp++; if (wr_ack !== (4'b0001 << (k % 4))) begin
        n_fail++; $display("FAIL rr_ack[%0d] got %b want %b", k, wr_ack, 4'b0001 << (k % 4));
      end
      n_cmp++; if (fifo_din !== 8'(8'h10 + k % 4)) begin
        n_fail++; $display("FAIL rr_din[%0d] got %h want %h", k, fifo_din, 8'(8'h10 + k % 4));
      end
      advance();
    end
    wr_req = '0; rd_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); predict();
      n_cmp++; if (rd_ack !== (k < 5)) begin n_fail++; $display("FAIL drain_ack[%0d] got %b want %b", k, rd_ack, k < 5); end
      if (k > 0) begin
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_rd[k-1]) begin
          n_fail++; $display("FAIL drain_data[%0d] got v=%b %h want v=1 %h", k, rd_valid, rd_data, exp_rd[k-1]);
        end
      end
      advance();
    end
    rd_req = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    wr_req = 4'b0100; rd_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      wr_data = {8'h00, 8'(k), 16'h0000};
      @(negedge clk); predict();
      n_cmp++; if (wr_ack !== 4'b0100) begin n_fail++; $display("FAIL fill_ack[%0d] got %b want 0100", k, wr_ack); end
      advance();
    end
    wr_data = {8'h00, 8'h55, 16'h0000};
    @(negedge clk); predict();
    n_cmp++; if (fifo_full !== 1'b1 || wr_ack !== '0 || fifo_wr !== 1'b0) begin
      n_fail++; $display("FAIL full_block got full=%b ack=%b wr=%b want 1 0000 0", fifo_full, wr_ack, fifo_wr);
    end
    advance();
    rd_req = 1'b1;
    @(negedge clk); predict();
    n_cmp++; if (rd_ack !== 1'b1 || fifo_rd !== 1'b1 || wr_ack !== '0) begin
      n_fail++; $display("FAIL full_read got rd_ack=%b fifo_rd=%b wr_ack=%b want 1 1 0000", rd_ack, fifo_rd, wr_ack);
    end
    advance();
    rd_req = 1'b0;
    @(negedge clk); predict();
    n_cmp++; if (wr_ack !== 4'b0100 || fifo_din !== 8'h55) begin
      n_fail++; $display("FAIL full_retry got ack=%b din=%h want 0100 55", wr_ack, fifo_din);
    end
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      n_fail++; $display("FAIL full_rdata got v=%b %h want v=1 00", rd_valid, rd_data);
    end
    advance();
    wr_req = '0;
    @(negedge clk); predict();
    n_cmp++; if (wr_cnt !== 16'd17 || rd_cnt !== 16'd1) begin
      n_fail++; $display("FAIL full_cnts got %0d/%0d want 17/1", wr_cnt, rd_cnt);
    end
    advance();
  endtask

  task automatic test_contention();
    do_reset();
    wr_req = 4'b0010; rd_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wr_data = {16'h0000, 8'(8'hC0 + k), 8'h00};
      @(negedge clk); predict();
      n_cmp++; if (wr_ack !== 4'b0010) begin n_fail++; $display("FAIL cont_fill[%0d] got %b want 0010", k, wr_ack); end
      advance();
    end
    wr_req = '0; rd_req = 1'b1;
    @(negedge clk); predict();
    n_cmp++; if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL cont_preread got %b want 1", rd_ack); end
    advance();
    wr_req = 4'b0010; wr_data = {16'h0000, 8'hD0, 8'h00};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); predict();
      n_cmp++; if (fifo_wr !== (k % 2 == 0) || fifo_rd !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL cont_op[%0d] got wr=%b rd=%b want %b %b", k, fifo_wr, fifo_rd, k % 2 == 0, k % 2 == 1);
      end
      n_cmp++; if (rd_valid !== (k % 2 == 0)) begin
        n_fail++; $display("FAIL cont_valid[%0d] got %b want %b", k, rd_valid, k % 2 == 0);
      end
      if (k % 2 == 0) begin
        n_cmp++; if (rd_data !== 8'(8'hC0 + k / 2)) begin
          n_fail++; $display("FAIL cont_rdata[%0d] got %h want %h", k, rd_data, 8'(8'hC0 + k / 2));
        end
      end
      advance();
    end
    wr_req = '0; rd_req = 1'b0;
  endtask

  task automatic test_empty();
    do_reset();
    rd_req = 1'b1; wr_req = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); predict();
      n_cmp++; if (rd_ack !== 1'b0 || rd_valid !== 1'b0) begin
        n_fail++; $display("FAIL empty_idle[%0d] got ack=%b v=%b want 0 0", k, rd_ack, rd_valid);
      end
      advance();
    end
    wr_req = 4'b0001; wr_data = {24'h000000, 8'hA5};
    @(negedge clk); predict();
    n_cmp++; if (wr_ack !== 4'b0001 || rd_ack !== 1'b0) begin
      n_fail++; $display("FAIL empty_write got ack=%b rd_ack=%b want 0001 0", wr_ack, rd_ack);
    end
    advance();
    wr_req = '0;
    @(negedge clk); predict();
    n_cmp++; if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL empty_read got %b want 1", rd_ack); end
    advance();
    rd_req = 1'b0;
    @(negedge clk); predict();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      n_fail++; $display("FAIL empty_rdata got v=%b %h want v=1 a5", rd_valid, rd_data);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_req = 4'b0011; rd_req = 1'b0; wr_data = 32'h4433_2211;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); predict();
      n_cmp++; if (wr_ack !== (4'b0001 << k)) begin
        n_fail++; $display("FAIL mid_pre[%0d] got %b want %b", k, wr_ack, 4'b0001 << k);
      end
      advance();
    end
    wr_req = '1; rd_req = 1'b1;
    @(negedge clk); predict();
    n_cmp++; if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL mid_read got %b want 1", rd_ack); end
    advance();
    @(negedge clk); predict();
    n_cmp++; if (wr_ack !== 4'b0100) begin n_fail++; $display("FAIL mid_write got %b want 0100", wr_ack); end
    advance();
    rst = 1'b1;
    @(negedge clk); predict();
    n_cmp++; if (wr_ack !== '0 || rd_ack !== 1'b0 || fifo_wr !== 1'b0 || fifo_rd !== 1'b0) begin
      n_fail++; $display("FAIL mid_suppress got ack=%b rd_ack=%b wr=%b rd=%b want all 0", wr_ack, rd_ack, fifo_wr, fifo_rd);
    end
    advance();
    rst = 1'b0;
    @(negedge clk); predict();
    n_cmp++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_cleared got %0d/%0d v=%b want 0/0 v=0", wr_cnt, rd_cnt, rd_valid);
    end
    n_cmp++; if (wr_ack !== 4'b0001 || rd_ack !== 1'b0) begin
      n_fail++; $display("FAIL mid_regrant got ack=%b rd_ack=%b want 0001 0", wr_ack, rd_ack);
    end
    advance();
    wr_req = '0; rd_req = 1'b0;
  endtask

  task automatic test_random();
    int rd_pct;
    logic [N-1:0] nreq;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rd_pct = (c < 200) ? 15 : (c < 400) ? 85 : (c < 600) ? 50 : 97;
      nreq = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!wr_req[i] && nreq[i]) wr_data[i*DW +: DW] = 8'($urandom);
      end
      wr_req = wr_req | nreq;
      rd_req = ($urandom_range(0, 99) < rd_pct);
      rst    = ($urandom_range(0, 149) == 0);
      @(negedge clk); predict();
      n_cmp++; if (wr_ack !== e_ack || fifo_wr !== p_wr) begin
        n_fail++; $display("FAIL rnd_wr[%0d] got ack=%b wr=%b want %b %b", c, wr_ack, fifo_wr, e_ack, p_wr);
      end
      n_cmp++; if (rd_ack !== p_rd || fifo_rd !== p_rd) begin
        n_fail++; $display("FAIL rnd_rd[%0d] got ack=%b rd=%b want %b", c, rd_ack, fifo_rd, p_rd);
      end
      if (p_wr) begin
        n_cmp++; if (fifo_din !== e_din) begin n_fail++; $display("FAIL rnd_din[%0d] got %h want %h", c, fifo_din, e_din); end
      end
      n_cmp++; if (rd_valid !== m_rdv) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", c, rd_valid, m_rdv); end
      if (m_rdv) begin
        n_cmp++; if (rd_data !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d] got %h want %h", c, rd_data, m_rdata); end
      end
      n_cmp++; if (wr_cnt !== 16'(m_wcnt) || rd_cnt !== 16'(m_rcnt)) begin
        n_fail++; $display("FAIL rnd_cnts[%0d] got %0d/%0d want %0d/%0d", c, wr_cnt, rd_cnt, m_wcnt, m_rcnt);
      end
      advance();
      if (p_wr) wr_req[p_g] = 1'b0;
    end
    rst = 1'b0; wr_req = '0; rd_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_req = '0; rd_req = 1'b0; wr_data = '0;
    test_reset();
    test_round_robin();
    test_full();
    test_contention();
    test_empty();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
